pipe_control: RTL and testbench

Pipelined successor to the single-cycle instruction decoder. Decodes the RV32I opcode in ID into a 12-bit control word and carries it, with the destination register, through ID/EX, EX/MEM and MEM/WB registers. Also generates the load-use interlock, the taken-branch flush and the data-memory freeze for the 5-stage core. It sits between the IF/ID register and the datapath/forwarding unit.

---
 rtl/pipe_control.sv | 124 ++++++++++++
 tb/tb_pipe_control.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// pipe_control: RV32I ID-stage decode feeding the EX/MEM/WB control-word pipeline, plus the stall, flush and freeze hazard controls.
module pipe_control #(
    parameter bit ILLEGAL_CHECK  = 1'b1,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_instr_id,
    input  logic        i_instr_valid,
    input  logic        i_ex_branch_taken,
    input  logic        i_mem_ready,
    output logic        o_stall_if,
    output logic        o_flush_ifid,
    output logic [11:0] o_ex_ctrl,
    output logic [11:0] o_mem_ctrl,
    output logic [11:0] o_wb_ctrl,
    output logic [4:0]  o_ex_rd,
    output logic [4:0]  o_mem_rd,
    output logic [4:0]  o_wb_rd,
    output logic        o_ex_illegal
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [6:0]  w_op;
    logic [2:0]  w_br;
    logic [11:0] w_ctrl;
    logic [11:0] w_dec_ctrl;
    logic [4:0]  w_rd;
    logic        w_known;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_illegal;
    logic        w_load_use;
    logic        w_freeze;
    logic        w_bubble;

    logic [11:0] r_ex_ctrl;
    logic [11:0] r_mem_ctrl;
    logic [11:0] r_wb_ctrl;
    logic [4:0]  r_ex_rd;
    logic [4:0]  r_mem_rd;
    logic [4:0]  r_wb_rd;
    logic        r_ex_illegal;

    assign w_op = i_instr_id[6:0];

    always_comb begin
        w_ctrl    = '0;
        w_known   = 1'b1;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (i_instr_id[14:12])
            3'b000:  w_br = 3'd1;
            3'b001:  w_br = 3'd2;
            3'b100:  w_br = 3'd3;
            3'b101:  w_br = 3'd4;
            3'b110:  w_br = 3'd5;
            3'b111:  w_br = 3'd6;
            default: w_br = 3'd0;
        endcase
        case (w_op)
            OP_R:     begin w_ctrl = 12'h802; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_I:     begin w_ctrl = 12'h803; w_use_rs1 = 1'b1; end
            OP_LOAD:  begin w_ctrl = 12'hB03; w_use_rs1 = 1'b1; end
            OP_JALR:  begin w_ctrl = 12'h80B; w_use_rs1 = 1'b1; end
            OP_S:     begin w_ctrl = 12'h402; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_B:     begin w_ctrl = {5'b0, w_br, 4'b0010}; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
            OP_LUI:   w_ctrl = 12'h800;
            OP_AUIPC: w_ctrl = 12'h804;
            OP_JAL:   w_ctrl = 12'h882;
            default:  w_known = 1'b0;
        endcase
    end

    assign w_dec_ctrl = i_instr_valid ? w_ctrl : 12'h000;
    assign w_rd       = w_dec_ctrl[11] ? i_instr_id[11:7] : 5'd0;
    assign w_illegal  = ILLEGAL_CHECK && i_instr_valid && !w_known;

    // x0 never carries a real value, so a load to x0 cannot create a hazard
    assign w_load_use = LOAD_USE_STALL && i_instr_valid && r_ex_ctrl[9] && (r_ex_rd != 5'd0) &&
                        ((w_use_rs1 && i_instr_id[19:15] == r_ex_rd) ||
                         (w_use_rs2 && i_instr_id[24:20] == r_ex_rd));
    assign w_freeze   = (r_mem_ctrl[10] | r_mem_ctrl[9]) & ~i_mem_ready;
    assign w_bubble   = i_ex_branch_taken | w_load_use;

    assign o_stall_if   = w_freeze | (w_load_use & ~i_ex_branch_taken);
    assign o_flush_ifid = i_ex_branch_taken & ~w_freeze;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ex_ctrl    <= '0;
            r_mem_ctrl   <= '0;
            r_wb_ctrl    <= '0;
            r_ex_rd      <= '0;
            r_mem_rd     <= '0;
            r_wb_rd      <= '0;
            r_ex_illegal <= 1'b0;
        end else if (!w_freeze) begin
            r_ex_ctrl    <= w_bubble ? 12'h000 : w_dec_ctrl;
            r_ex_rd      <= w_bubble ? 5'd0 : w_rd;
            r_ex_illegal <= !w_bubble && w_illegal;
            r_mem_ctrl   <= r_ex_ctrl;
            r_mem_rd     <= r_ex_rd;
            r_wb_ctrl    <= r_mem_ctrl;
            r_wb_rd      <= r_mem_rd;
        end
    end

    assign o_ex_ctrl    = r_ex_ctrl;
    assign o_mem_ctrl   = r_mem_ctrl;
    assign o_wb_ctrl    = r_wb_ctrl;
    assign o_ex_rd      = r_ex_rd;
    assign o_mem_rd     = r_mem_rd;
    assign o_wb_rd      = r_wb_rd;
    assign o_ex_illegal = r_ex_illegal;
endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed hazard scenarios plus random traffic against a stage-slot reference model, for both parameter settings.
module tb_pipe_control;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, instr_valid = 1'b0, ex_branch_taken = 1'b0, mem_ready = 1'b1;
    logic [31:0] instr_id = '0;
    logic        stall_if [2], flush_ifid [2], ex_illegal [2];
    logic [11:0] ex_ctrl [2], mem_ctrl [2], wb_ctrl [2];
    logic [4:0]  ex_rd [2], mem_rd [2], wb_rd [2];

    pipe_control #(.ILLEGAL_CHECK(1'b1), .LOAD_USE_STALL(1'b1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_id(instr_id), .i_instr_valid(instr_valid),
        .i_ex_branch_taken(ex_branch_taken), .i_mem_ready(mem_ready),
        .o_stall_if(stall_if[0]), .o_flush_ifid(flush_ifid[0]),
        .o_ex_ctrl(ex_ctrl[0]), .o_mem_ctrl(mem_ctrl[0]), .o_wb_ctrl(wb_ctrl[0]),
        .o_ex_rd(ex_rd[0]), .o_mem_rd(mem_rd[0]), .o_wb_rd(wb_rd[0]), .o_ex_illegal(ex_illegal[0])
    );

    pipe_control #(.ILLEGAL_CHECK(1'b0), .LOAD_USE_STALL(1'b0)) u_alt (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_id(instr_id), .i_instr_valid(instr_valid),
        .i_ex_branch_taken(ex_branch_taken), .i_mem_ready(mem_ready),
        .o_stall_if(stall_if[1]), .o_flush_ifid(flush_ifid[1]),
        .o_ex_ctrl(ex_ctrl[1]), .o_mem_ctrl(mem_ctrl[1]), .o_wb_ctrl(wb_ctrl[1]),
        .o_ex_rd(ex_rd[1]), .o_mem_rd(mem_rd[1]), .o_wb_rd(wb_rd[1]), .o_ex_illegal(ex_illegal[1])
    );

    localparam logic [31:0] LW = 32'h0000A283, ADD = 32'h00228333, BEQ = 32'h00208463;
    localparam logic [31:0] SW = 32'h0050A023, ADDI = 32'h00100093;

    typedef struct packed { logic [11:0] c; logic [4:0] rd; logic il; } slot_t;
    slot_t m_ex [2], m_mem [2], m_wb [2];
    bit    ill_on [2] = '{1'b1, 1'b0};
    bit    lu_on [2] = '{1'b1, 1'b0};
    logic  c_stall [2], c_flush [2];
    int    n_cmp = 0, n_bad = 0;
    bit    armed = 1'b0;
    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Control word assembled from its named fields as the decode table lists them
    function automatic logic [11:0] decode(input logic [31:0] ins);
        bit rw = 0, mw = 0, mr = 0, m2r = 0, js = 0, jr = 0, us = 0, uj = 0, as = 0;
        logic [2:0] b = 3'd0, f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: begin rw = 1; uj = 1; end
            7'b0010011: begin rw = 1; uj = 1; as = 1; end
            7'b0000011: begin rw = 1; mr = 1; m2r = 1; uj = 1; as = 1; end
            7'b1100111: begin rw = 1; jr = 1; uj = 1; as = 1; end
            7'b0100011: begin mw = 1; uj = 1; end
            7'b1100011: begin uj = 1; b = (f3 < 3'd2) ? f3 + 3'd1 : (f3 >= 3'd4) ? f3 - 3'd1 : 3'd0; end
            7'b0110111: rw = 1;
            7'b0010111: begin rw = 1; us = 1; end
            7'b1101111: begin rw = 1; js = 1; uj = 1; end
            default: ;
        endcase
        return {rw, mw, mr, m2r, js, b, jr, us, uj, as};
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic v, input logic bt, input logic mr, input logic rn);
        slot_t nx_ex [2], nx_mem [2], nx_wb [2];
        instr_id = ins; instr_valid = v; ex_branch_taken = bt; mem_ready = mr; rst_n = rn;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit frz, lu;
            slot_t s;
            frz = (m_mem[k].c[10] || m_mem[k].c[9]) && !mr;
            lu = lu_on[k] && v && m_ex[k].c[9] && m_ex[k].rd != 5'd0 &&
                 ((reads_rs1(ins[6:0]) && ins[19:15] == m_ex[k].rd) ||
                  (reads_rs2(ins[6:0]) && ins[24:20] == m_ex[k].rd));
            c_stall[k] = stall_if[k];
            c_flush[k] = flush_ifid[k];
            if (armed) begin
                chk($sformatf("stall_if[%0d]", k), 32'(stall_if[k]), 32'(frz || (lu && !bt)));
                chk($sformatf("flush_ifid[%0d]", k), 32'(flush_ifid[k]), 32'(!frz && bt));
            end
            s.c  = v ? decode(ins) : 12'h000;
            s.rd = s.c[11] ? ins[11:7] : 5'd0;
            s.il = ill_on[k] && v && decode(ins) == 12'h000;
            nx_ex[k] = m_ex[k]; nx_mem[k] = m_mem[k]; nx_wb[k] = m_wb[k];
            if (!rn) begin
                nx_ex[k] = '0; nx_mem[k] = '0; nx_wb[k] = '0;
            end else if (!frz) begin
                nx_wb[k] = m_mem[k]; nx_mem[k] = m_ex[k];
                nx_ex[k] = (bt || lu) ? slot_t'(0) : s;
            end
        end
        @(posedge clk);
        #1;
        armed = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = nx_ex[k]; m_mem[k] = nx_mem[k]; m_wb[k] = nx_wb[k];
            chk($sformatf("ex_ctrl[%0d]", k), 32'(ex_ctrl[k]), 32'(m_ex[k].c));
            chk($sformatf("ex_rd[%0d]", k), 32'(ex_rd[k]), 32'(m_ex[k].rd));
            chk($sformatf("ex_illegal[%0d]", k), 32'(ex_illegal[k]), 32'(m_ex[k].il));
            chk($sformatf("mem_ctrl[%0d]", k), 32'(mem_ctrl[k]), 32'(m_mem[k].c));
            chk($sformatf("mem_rd[%0d]", k), 32'(mem_rd[k]), 32'(m_mem[k].rd));
            chk($sformatf("wb_ctrl[%0d]", k), 32'(wb_ctrl[k]), 32'(m_wb[k].c));
            chk($sformatf("wb_rd[%0d]", k), 32'(wb_rd[k]), 32'(m_wb[k].rd));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_ex[k] = '0; m_mem[k] = '0; m_wb[k] = '0; end
        cyc(ADD, 1, 0, 0, 0);
        cyc(ADD, 1, 0, 0, 0);
        chk("reset_ex_ctrl", 32'(ex_ctrl[0]), 0);
        chk("reset_stall", 32'(stall_if[0]), 0);
        chk("reset_flush", 32'(flush_ifid[0]), 0);

        cyc(LW, 1, 0, 1, 1);
        chk("lu_lw_ex", 32'(ex_ctrl[0]), 32'hB03);
        cyc(ADD, 1, 0, 1, 1);
        chk("lu_stall", 32'(c_stall[0]), 1);
        chk("lu_bubble", 32'(ex_ctrl[0]), 0);
        chk("lu_off_nostall", 32'(c_stall[1]), 0);
        cyc(ADD, 1, 0, 1, 1);
        chk("lu_release", 32'(c_stall[0]), 0);
        chk("lu_add_ctrl", 32'(ex_ctrl[0]), 32'h802);
        chk("lu_add_rd", 32'(ex_rd[0]), 6);

        cyc(BEQ, 1, 0, 1, 1);
        chk("beq_ctrl", 32'(ex_ctrl[0]), 32'h012);
        cyc(LW, 1, 1, 1, 1);
        chk("br_flush", 32'(c_flush[0]), 1);
        chk("br_bubble", 32'(ex_ctrl[0]), 0);
        cyc(LW, 1, 0, 1, 1);
        cyc(ADD, 1, 1, 1, 1);
        chk("br_lu_flush", 32'(c_flush[0]), 1);
        chk("br_lu_nostall", 32'(c_stall[0]), 0);
        chk("br_lu_bubble", 32'(ex_ctrl[0]), 0);

        cyc(SW, 1, 0, 1, 1);
        cyc(ADD, 1, 0, 1, 1);
        chk("frz_sw_mem", 32'(mem_ctrl[0]), 32'h402);
        for (int i = 0; i < 3; i++) begin
            cyc(ADDI, 1, 0, 0, 1);
            chk("frz_stall", 32'(c_stall[0]), 1);
            chk("frz_ex_hold", 32'(ex_ctrl[0]), 32'h802);
            chk("frz_mem_hold", 32'(mem_ctrl[0]), 32'h402);
        end
        cyc(ADDI, 1, 0, 1, 1);
        chk("frz_rel_ex", 32'(ex_ctrl[0]), 32'h803);
        chk("frz_rel_wb", 32'(wb_ctrl[0]), 32'h402);

        cyc(32'h0000007F, 1, 0, 1, 1);
        chk("ill_ctrl", 32'(ex_ctrl[0]), 0);
        chk("ill_on", 32'(ex_illegal[0]), 1);
        chk("ill_off", 32'(ex_illegal[1]), 0);
        cyc(ADDI, 1, 0, 1, 1);
        chk("ill_clear", 32'(ex_illegal[0]), 0);

        cyc(32'h0000A003, 1, 0, 1, 1);
        cyc(32'h00200333, 1, 0, 1, 1);
        chk("x0_nostall", 32'(c_stall[0]), 0);

        cyc(SW, 1, 0, 1, 1);
        cyc(ADDI, 1, 0, 1, 1);
        cyc(ADDI, 1, 0, 0, 1);
        chk("rstfrz_stall", 32'(c_stall[0]), 1);
        cyc(ADDI, 1, 0, 0, 0);
        chk("rstfrz_mem", 32'(mem_ctrl[0]), 0);
        chk("rstfrz_stall_after", 32'(stall_if[0]), 0);

        cyc(32'h123450B7, 1, 0, 1, 1);
        chk("dec_lui", 32'(ex_ctrl[0]), 32'h800);
        cyc(32'h00000117, 1, 0, 1, 1);
        chk("dec_auipc", 32'(ex_ctrl[0]), 32'h804);
        cyc(32'h008000EF, 1, 0, 1, 1);
        chk("dec_jal", 32'(ex_ctrl[0]), 32'h882);
        cyc(32'h000080E7, 1, 0, 1, 1);
        chk("dec_jalr", 32'(ex_ctrl[0]), 32'h80B);

        for (int i = 0; i < 1500; i++) begin
            int pick;
            logic [6:0] op;
            logic [31:0] ins;
            pick = $urandom_range(0, 10);
            op = (pick == 10) ? 7'($urandom) : ops[pick];
            ins = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   3'($urandom), 5'($urandom_range(0, 3)), op};
            cyc(ins, ($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 3) != 0, ($urandom % 50) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
